// File: rtl/rst_seq_pkg.sv
// Shared types for the reset/PLL sequencer.
// State encoding and counter width helper.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_PLLRST   = 3'd0,
    S_WAITLOCK = 3'd1,
    S_RELEASE  = 3'd2,
    S_RUN      = 3'd3,
    S_FAIL     = 3'd4
  } state_t;

  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Reset value is chosen per instance so reset looks idle.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // metastability stage followed by the output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Reset/PLL sequencer: PLL reset pulses, lock filter,
// timeout retry and staged release of channel resets.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int PLL_RST_CYC  = 8,
  parameter int LOCK_FILT    = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int RETRY_MAX    = 3,
  parameter int STAGE_DLY    = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            EXT_RESET_N,
  input  logic            PLL_LOCKED,
  input  logic            SW_RESET_REQ,
  output logic            PLL_RESET_N,
  output logic [N_CH-1:0] CH_RESET,
  output logic            SEQ_DONE,
  output logic            LOCK_FAIL,
  output logic [2:0]      STATE
);

  localparam int PW = cnt_w(PLL_RST_CYC);
  localparam int LW = cnt_w(LOCK_FILT);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int RW = cnt_w(RETRY_MAX);
  localparam int GW = cnt_w(STAGE_DLY);

  localparam logic [PW-1:0] PLL_LAST = PW'(PLL_RST_CYC - 1);
  localparam logic [LW-1:0] LF_MAX   = LW'(LOCK_FILT);
  localparam logic [LW-1:0] LF_PRE   = LW'(LOCK_FILT - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] R_MAX    = RW'(RETRY_MAX);
  localparam logic [GW-1:0] STG_LAST = GW'(STAGE_DLY - 1);

  logic            ext_rst;
  logic            lock;
  logic [LW-1:0]   lf_cnt;
  logic            lock_ok;
  logic            lock_ok_d;
  logic            lock_drop;
  state_t          state;
  state_t          nxt;
  logic [PW-1:0]   pll_cnt;
  logic [PW-1:0]   pll_nx;
  logic [TW-1:0]   to_cnt;
  logic [TW-1:0]   to_nx;
  logic [GW-1:0]   stg_cnt;
  logic [GW-1:0]   stg_nx;
  logic [RW-1:0]   retry;
  logic [RW-1:0]   retry_nx;
  logic [N_CH-1:0] ch_rst;
  logic [N_CH-1:0] ch_nx;
  logic [N_CH-1:0] ch_sh;
  logic            pll_rst_n;
  logic            seq_done;
  logic            lock_fail;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_ext (
    .clk (CLK),
    .rst (RESET),
    .d   (EXT_RESET_N),
    .q   (ext_rst)
  );

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_lock (
    .clk (CLK),
    .rst (RESET),
    .d   (PLL_LOCKED),
    .q   (lock)
  );

  // FSM reacts to the value lock_ok is about to take
  assign lock_ok_d = lock & (lf_cnt >= LF_PRE);
  assign lock_drop = lock_ok & ~lock_ok_d;
  assign ch_sh     = ch_rst << 1;

  // saturating run-length filter on synced lock
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lf_cnt  <= '0;
      lock_ok <= 1'b0;
    end else begin
      lock_ok <= lock_ok_d;
      if (!lock) begin
        lf_cnt <= '0;
      end else if (lf_cnt != LF_MAX) begin
        lf_cnt <= lf_cnt + LW'(1);
      end
    end
  end

  // next state, counters and thermometer channel mask
  always_comb begin
    nxt      = state;
    pll_nx   = '0;
    to_nx    = '0;
    stg_nx   = '0;
    retry_nx = retry;
    ch_nx    = '1;
    if (!ext_rst) begin
      nxt      = S_PLLRST;
      retry_nx = '0;
    end else begin
      unique case (state)
        S_PLLRST: begin
          if (pll_cnt == PLL_LAST) begin
            nxt = S_WAITLOCK;
          end else begin
            pll_nx = pll_cnt + PW'(1);
          end
        end
        S_WAITLOCK: begin
          if (lock_ok_d) begin
            nxt = S_RELEASE;
          end else if (to_cnt == TO_LAST) begin
            if (retry < R_MAX) begin
              retry_nx = retry + RW'(1);
              nxt      = S_PLLRST;
            end else begin
              nxt = S_FAIL;
            end
          end else begin
            to_nx = to_cnt + TW'(1);
          end
        end
        S_RELEASE: begin
          if (lock_drop) begin
            nxt = S_WAITLOCK;
          end else if (!SW_RESET_REQ) begin
            ch_nx = ch_rst;
            if (stg_cnt == STG_LAST) begin
              ch_nx = ch_sh;
              if (ch_sh == '0) begin
                nxt      = S_RUN;
                retry_nx = '0;
              end
            end else begin
              stg_nx = stg_cnt + GW'(1);
            end
          end
        end
        S_RUN: begin
          if (lock_drop) begin
            nxt = S_WAITLOCK;
          end else if (SW_RESET_REQ) begin
            nxt = S_RELEASE;
          end else begin
            ch_nx = '0;
          end
        end
        S_FAIL: begin
          nxt = S_FAIL;
        end
        default: begin
          nxt = S_PLLRST;
        end
      endcase
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_PLLRST;
      pll_cnt   <= '0;
      to_cnt    <= '0;
      stg_cnt   <= '0;
      retry     <= '0;
      ch_rst    <= '1;
      pll_rst_n <= 1'b0;
      seq_done  <= 1'b0;
      lock_fail <= 1'b0;
    end else begin
      state     <= nxt;
      pll_cnt   <= pll_nx;
      to_cnt    <= to_nx;
      stg_cnt   <= stg_nx;
      retry     <= retry_nx;
      ch_rst    <= ch_nx;
      pll_rst_n <= (nxt != S_PLLRST);
      seq_done  <= (nxt == S_RUN);
      lock_fail <= (nxt == S_FAIL);
    end
  end

  assign PLL_RESET_N = pll_rst_n;
  assign CH_RESET    = ch_rst;
  assign SEQ_DONE    = seq_done;
  assign LOCK_FAIL   = lock_fail;
  assign STATE       = state;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: phase/elapsed-time model
// checked every cycle, plus hand-computed timings.
module tb_rst_sequencer;

  localparam int N_CH         = 4;
  localparam int PLL_RST_CYC  = 8;
  localparam int LOCK_FILT    = 16;
  localparam int LOCK_TIMEOUT = 64;
  localparam int RETRY_MAX    = 3;
  localparam int STAGE_DLY    = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ext_n = 1'b1;
  logic            locked = 1'b0;
  logic            sw = 1'b0;
  logic            pll_n;
  logic [N_CH-1:0] ch;
  logic            done;
  logic            fail;
  logic [2:0]      st;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  rst_sequencer #(
    .N_CH         (N_CH),
    .PLL_RST_CYC  (PLL_RST_CYC),
    .LOCK_FILT    (LOCK_FILT),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .RETRY_MAX    (RETRY_MAX),
    .STAGE_DLY    (STAGE_DLY)
  ) dut (
    .CLK          (clk),
    .RESET        (rst),
    .EXT_RESET_N  (ext_n),
    .PLL_LOCKED   (locked),
    .SW_RESET_REQ (sw),
    .PLL_RESET_N  (pll_n),
    .CH_RESET     (ch),
    .SEQ_DONE     (done),
    .LOCK_FAIL    (fail),
    .STATE        (st)
  );

  always #5 clk = ~clk;

  // model: phase code, cycles spent in phase, lock run length
  int m_phase = 0;
  int m_t = 0;
  int m_retry = 0;
  int m_run = 0;
  bit m_e1 = 1'b1;
  bit m_e2 = 1'b1;
  bit m_l1 = 1'b0;
  bit m_l2 = 1'b0;

  always @(posedge clk) begin : model
    bit okn;
    if (rst) begin
      m_e1 = 1'b1; m_e2 = 1'b1;
      m_l1 = 1'b0; m_l2 = 1'b0;
      m_run = 0; m_phase = 0;
      m_t = 0; m_retry = 0;
    end else begin
      m_run = m_l2 ? m_run + 1 : 0;
      okn = (m_run >= LOCK_FILT);
      if (!m_e2) begin
        m_phase = 0; m_t = 0; m_retry = 0;
      end else begin
        case (m_phase)
          0: begin
            m_t++;
            if (m_t == PLL_RST_CYC) begin
              m_phase = 1; m_t = 0;
            end
          end
          1: begin
            if (okn) begin
              m_phase = 2; m_t = 0;
            end else begin
              m_t++;
              if (m_t == LOCK_TIMEOUT) begin
                m_t = 0;
                if (m_retry < RETRY_MAX) begin
                  m_retry++; m_phase = 0;
                end else begin
                  m_phase = 4;
                end
              end
            end
          end
          2: begin
            if (!okn) begin
              m_phase = 1; m_t = 0;
            end else if (sw) begin
              m_t = 0;
            end else begin
              m_t++;
              if (m_t == STAGE_DLY * N_CH) begin
                m_phase = 3; m_retry = 0;
              end
            end
          end
          3: begin
            if (!okn) begin
              m_phase = 1; m_t = 0;
            end else if (sw) begin
              m_phase = 2; m_t = 0;
            end
          end
          default: ;
        endcase
      end
      m_e2 = m_e1; m_e1 = ext_n;
      m_l2 = m_l1; m_l1 = locked;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    logic [3:0] ech;
    logic [9:0] e;
    logic [9:0] a;
    if (chk_en) begin
      if (m_phase == 2) ech = 4'hF << (m_t / STAGE_DLY);
      else if (m_phase == 3) ech = 4'h0;
      else ech = 4'hF;
      e = {m_phase != 0, ech, m_phase == 3,
           m_phase == 4, 3'(m_phase)};
      a = {pll_n, ch, done, fail, st};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle t=%0t got %b want %b",
                 $time, a, e);
      end
    end
  end

  task automatic check(input string name,
                       input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d",
               name, got, want);
    end
  endtask

  task automatic wait_for(input int code, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 2000) begin
      @(negedge clk);
      n++;
      case (code)
        0: hit = pll_n;
        1: hit = !ch[0];
        2: hit = done;
        3: hit = fail;
        4: hit = (ch == 4'hF);
        5: hit = (st == 3'd2);
        6: hit = (ch == 4'hE);
        7: hit = (ch == 4'hC);
        default: hit = 1'b1;
      endcase
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_timeout code %0d", code);
    end
  endtask

  task automatic do_reset(input logic lk);
    @(negedge clk);
    rst = 1'b1; locked = lk;
    ext_n = 1'b1; sw = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sw_pulse();
    @(negedge clk);
    sw = 1'b1;
    @(negedge clk);
    sw = 1'b0;
  endtask

  initial begin
    int n;
    int t;
    int lows;
    int pulses;
    bit prev;
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_pll_n", int'(pll_n), 0);
    check("reset_ch", int'(ch), 15);

    // 1: lock held high through reset
    do_reset(1'b1);
    wait_for(0, n);
    check("pll_rst_len", n, 8);
    t = n;
    wait_for(1, n);
    check("ch0_release", t + n, 50);
    t += n;
    wait_for(2, n);
    check("seq_done_at", t + n, 146);
    check("run_ch", int'(ch), 0);

    // 2: one-cycle lock glitch after 10 highs
    do_reset(1'b0);
    locked = 1'b1;
    repeat (10) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    wait_for(5, n);
    check("glitch_release", n + 11, 29);
    wait_for(2, n);

    // 4: lock loss in RUN, then relock
    @(negedge clk);
    locked = 1'b0;
    wait_for(4, n);
    check("loss_latency", n, 3);
    check("loss_no_pllrst", int'(pll_n), 1);
    check("loss_state", int'(st), 1);
    repeat (10) @(negedge clk);
    locked = 1'b1;
    wait_for(2, n);
    check("relock_seq", n, 146);

    // 5: software reset in RUN and mid-release
    sw_pulse();
    check("sw_ch", int'(ch), 15);
    check("sw_pll_n", int'(pll_n), 1);
    check("sw_state", int'(st), 2);
    wait_for(6, n);
    check("sw_ch0", n, 32);
    sw_pulse();
    check("sw_restart_ch", int'(ch), 15);
    wait_for(1, n);
    check("sw_restart_ch0", n, 32);
    wait_for(2, n);

    // 6: external reset mid-release
    sw_pulse();
    wait_for(7, n);
    ext_n = 1'b0;
    repeat (5) @(negedge clk);
    ext_n = 1'b1;
    wait_for(0, n);
    check("ext_pll_len", n, 10);
    wait_for(2, n);
    check("ext_resequence", int'(ch), 0);

    // 3: lock never arrives
    do_reset(1'b0);
    prev = 1'b1; lows = 0; pulses = 0; n = 0;
    while (!fail && n < 1000) begin
      if (!pll_n) begin
        lows++;
        if (prev) pulses++;
      end
      prev = pll_n;
      @(negedge clk);
      n++;
    end
    check("fail_at", n, 288);
    check("pll_pulses", pulses, 4);
    check("pll_low_cycles", lows, 32);
    check("fail_state", int'(st), 4);
    check("fail_ch", int'(ch), 15);
    ext_n = 1'b0;
    repeat (3) @(negedge clk);
    check("ext_clears_fail", int'(fail), 0);
    ext_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
